serializer_tx: RTL

Parallel-to-serial transmitter that feeds the serial-input port of the general-purpose `register` block. It accepts a DATA_WIDTH word over a valid/ready handshake and emits it one bit at a time on `sout`, with a one-cycle `sshift` strobe per bit. The strobe and bit are meant to drive a receiving register directly:

- LSB-first frames go to `sr`/`ir`.
- MSB-first frames go to `sl`/`il`.

After DATA_WIDTH strobes the receiving register holds exactly the transmitted word.

---
 rtl/serializer_tx.sv | 95 +++++++++
 1 files changed

// File: rtl/serializer_tx.sv
// Parallel-to-serial transmitter: one DATA_WIDTH word out on sout with a per-bit sshift strobe.
// Latency: strobe n lands BIT_CYCLES*n cycles after the handshake; done follows the last strobe by one cycle.
// Backpressure: in_ready only in IDLE, so a new word waits until the current frame (or an abort) completes.
module serializer_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int BIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  msb_first,
  input  logic                  abort,
  output logic                  sout,
  output logic                  sshift,
  output logic                  busy,
  output logic                  done
);

  localparam int BCW = $clog2(DATA_WIDTH);
  localparam int DCW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BCW-1:0] BLAST = BCW'(DATA_WIDTH - 1);
  localparam logic [DCW-1:0] DLAST = DCW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  ord_q, ord_d;
  logic [BCW-1:0]        bcnt_q, bcnt_d;
  logic [DCW-1:0]        dcnt_q, dcnt_d;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    ord_d   = ord_q;
    bcnt_d  = bcnt_q;
    dcnt_d  = dcnt_q;
    if (abort) begin
      // Cancel wins over everything, including a pending handshake.
      state_d = IDLE;
      sh_d    = '0;
      bcnt_d  = '0;
      dcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_d = SHIFT;
            sh_d    = in_data;
            ord_d   = msb_first;
            bcnt_d  = '0;
            dcnt_d  = '0;
          end
        end
        SHIFT: begin
          if (dcnt_q != DLAST) begin
            dcnt_d = dcnt_q + 1'b1;
          end else begin
            dcnt_d = '0;
            sh_d   = ord_q ? {sh_q[DATA_WIDTH-2:0], 1'b0} : {1'b0, sh_q[DATA_WIDTH-1:1]};
            if (bcnt_q == BLAST) state_d = DONE;
            else                 bcnt_d  = bcnt_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      ord_q   <= 1'b0;
      bcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      ord_q   <= ord_d;
      bcnt_q  <= bcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = !in_ready;
  assign done     = (state_q == DONE);
  assign sshift   = (state_q == SHIFT) && (dcnt_q == DLAST);
  assign sout     = (state_q == SHIFT) ? (ord_q ? sh_q[DATA_WIDTH-1] : sh_q[0]) : 1'b0;

endmodule
